// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } rx_cfg_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Centre of a bit period in clock cycles.
  function automatic int mid_of(input int clks);
    return clks / 2;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Output word handshake and per-frame status between the receiver and its consumer.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;
  logic                 busy;

  modport master (
    output data_out, data_valid, frame_err, parity_err, overrun_err, busy,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, frame_err, parity_err, overrun_err, busy,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// RX synchroniser, bit-period counter and 2-of-3 mid-bit majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic clr_i,
  output logic rx_s_o,
  output logic bit_tick_o,
  output logic voted_bit_o
);
  localparam int MID = mid_of(CLKS_PER_BIT);
  localparam int CW  = $clog2(CLKS_PER_BIT);

  logic          rx_meta_q, rx_s_q;
  logic          s0_q, s1_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || cnt_q == CW'(CLKS_PER_BIT-1)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      cnt_q     <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_d;
      if (cnt_q == CW'(MID-1)) s0_q <= rx_s_q;
      if (cnt_q == CW'(MID))   s1_q <= rx_s_q;
    end
  end

  // Third sample is the live synchronised line, so the vote resolves at MID+1.
  assign rx_s_o      = rx_s_q;
  assign bit_tick_o  = !clr_i && (cnt_q == CW'(MID+1));
  assign voted_bit_o = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity and stop bits, with valid/ready output.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_rx_cfg_if.master rx_if
);
  rx_cfg_state_e        state_q, state_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_bad_q, par_bad_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
  logic                 commit;
  logic                 rx_s, bit_tick, voted;

  uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx),
    .clr_i      (state_q == S_IDLE),
    .rx_s_o     (rx_s),
    .bit_tick_o (bit_tick),
    .voted_bit_o(voted)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    par_bad_d  = par_bad_q;
    data_d     = data_q;
    valid_d    = valid_q;
    fe_d       = 1'b0;
    pe_d       = 1'b0;
    ov_d       = 1'b0;
    commit     = 1'b0;
    case (state_q)
      S_IDLE: if (!rx_s) state_d = S_START;
      S_START: if (bit_tick) begin
        if (voted) state_d = S_IDLE;
        else begin
          state_d    = S_DATA;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          par_bad_d  = 1'b0;
        end
      end
      S_DATA: if (bit_tick) begin
        shreg_d   = {voted, shreg_q[DATA_BITS-1:1]};
        bit_idx_d = bit_idx_q + 4'd1;
        if (bit_idx_q == 4'(DATA_BITS-1))
          state_d = (PARITY_MODE != PAR_NONE) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (bit_tick) begin
        par_bad_d = ((^shreg_q) ^ voted) != (PARITY_MODE == PAR_ODD);
        state_d   = S_STOP;
      end
      // Leave at mid-stop so the next start edge is caught without slip.
      S_STOP: if (bit_tick) begin
        if (!voted) begin
          fe_d    = 1'b1;
          state_d = S_WAIT_HIGH;
        end else if (stop_idx_q == 1'(STOP_BITS-1)) begin
          state_d = S_IDLE;
          if (par_bad_q) pe_d = 1'b1;
          else           commit = 1'b1;
        end else begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      if (!valid_q || rx_if.data_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (valid_q && rx_if.data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      par_bad_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      par_bad_q  <= par_bad_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      ov_q       <= ov_d;
    end
  end

  assign rx_if.data_out    = data_q;
  assign rx_if.data_valid  = valid_q;
  assign rx_if.frame_err   = fe_q;
  assign rx_if.parity_err  = pe_q;
  assign rx_if.overrun_err = ov_q;
  assign rx_if.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances sharing clk/rst.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) ifc0 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) ifc1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) ifc2 ();

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .rx(rx0), .rx_if(ifc0));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .rx(rx1), .rx_if(ifc1));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2))
    dut2 (.clk(clk), .rst(rst), .rx(rx2), .rx_if(ifc2));

  int nvec = 0, nerr = 0;
  int vcnt[3] = '{0, 0, 0};
  int fecnt[3] = '{0, 0, 0};
  int pecnt[3] = '{0, 0, 0};
  int ovcnt[3] = '{0, 0, 0};
  logic [8:0] cap[3] = '{9'h0, 9'h0, 9'h0};

  // Event counters and last-consumed word per instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (ifc0.data_valid) vcnt[0]++;
    if (ifc1.data_valid) vcnt[1]++;
    if (ifc2.data_valid) vcnt[2]++;
    if (ifc0.frame_err) fecnt[0]++;
    if (ifc1.frame_err) fecnt[1]++;
    if (ifc2.frame_err) fecnt[2]++;
    if (ifc0.parity_err) pecnt[0]++;
    if (ifc1.parity_err) pecnt[1]++;
    if (ifc2.parity_err) pecnt[2]++;
    if (ifc0.overrun_err) ovcnt[0]++;
    if (ifc1.overrun_err) ovcnt[1]++;
    if (ifc2.overrun_err) ovcnt[2]++;
    if (ifc0.data_valid && ifc0.data_ready) cap[0] = {1'b0, ifc0.data_out};
    if (ifc1.data_valid && ifc1.data_ready) cap[1] = {2'b0, ifc1.data_out};
    if (ifc2.data_valid && ifc2.data_ready) cap[2] = {1'b0, ifc2.data_out};
  end

  task automatic set_rx(input int d, input logic b);
    case (d)
      0:       rx0 = b;
      1:       rx1 = b;
      default: rx2 = b;
    endcase
  endtask

  // One bit period; optional one-clock inverted glitch at offset g.
  task automatic send_bit(input int d, input logic b, input int g);
    set_rx(d, b);
    if (g >= 0) begin
      repeat (g) @(posedge clk);
      #1 set_rx(d, ~b);
      @(posedge clk);
      #1 set_rx(d, b);
      repeat (CPB - g - 1) @(posedge clk);
      #1;
    end else begin
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                            input bit par_en, input logic par_bit, input int nstop,
                            input logic stop_val, input int gbit);
    send_bit(d, 1'b0, -1);
    for (int i = 0; i < nbits; i++) send_bit(d, data[i], (i == gbit) ? 9 : -1);
    if (par_en) send_bit(d, par_bit, -1);
    for (int i = 0; i < nstop; i++) send_bit(d, stop_val, -1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    nvec++; if ({ifc0.data_out, ifc0.data_valid, ifc0.frame_err, ifc0.parity_err, ifc0.overrun_err, ifc0.busy} !== '0) begin
      nerr++; $display("FAIL reset_dut0 got %h exp 0", {ifc0.data_out, ifc0.data_valid, ifc0.frame_err, ifc0.parity_err, ifc0.overrun_err, ifc0.busy}); end
    nvec++; if ({ifc1.data_out, ifc1.data_valid, ifc1.frame_err, ifc1.parity_err, ifc1.overrun_err, ifc1.busy} !== '0) begin
      nerr++; $display("FAIL reset_dut1 got %h exp 0", {ifc1.data_out, ifc1.data_valid, ifc1.frame_err, ifc1.parity_err, ifc1.overrun_err, ifc1.busy}); end
    nvec++; if ({ifc2.data_out, ifc2.data_valid, ifc2.frame_err, ifc2.parity_err, ifc2.overrun_err, ifc2.busy} !== '0) begin
      nerr++; $display("FAIL reset_dut2 got %h exp 0", {ifc2.data_out, ifc2.data_valid, ifc2.frame_err, ifc2.parity_err, ifc2.overrun_err, ifc2.busy}); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_8n1();
    int v = vcnt[0], e = fecnt[0] + pecnt[0] + ovcnt[0];
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (vcnt[0] - v !== 1) begin nerr++; $display("FAIL 8n1_valid_cycles got %0d exp 1", vcnt[0] - v); end
    nvec++; if (cap[0] !== 9'h0A5) begin nerr++; $display("FAIL 8n1_consumed got %h exp a5", cap[0]); end
    nvec++; if (ifc0.data_out !== 8'hA5) begin nerr++; $display("FAIL 8n1_data_out got %h exp a5", ifc0.data_out); end
    nvec++; if (fecnt[0] + pecnt[0] + ovcnt[0] - e !== 0) begin nerr++; $display("FAIL 8n1_err_pulses got %0d exp 0", fecnt[0] + pecnt[0] + ovcnt[0] - e); end
    nvec++; if (ifc0.busy !== 1'b0) begin nerr++; $display("FAIL 8n1_busy got %b exp 0", ifc0.busy); end
  endtask

  task automatic test_parity();
    int v = vcnt[1], p = pecnt[1];
    send_frame(1, 9'h035, 7, 1'b1, 1'b0, 1, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (vcnt[1] - v !== 1) begin nerr++; $display("FAIL par_good_valid got %0d exp 1", vcnt[1] - v); end
    nvec++; if (ifc1.data_out !== 7'h35) begin nerr++; $display("FAIL par_good_data got %h exp 35", ifc1.data_out); end
    nvec++; if (pecnt[1] - p !== 0) begin nerr++; $display("FAIL par_good_perr got %0d exp 0", pecnt[1] - p); end
    v = vcnt[1];
    send_frame(1, 9'h035, 7, 1'b1, 1'b1, 1, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (pecnt[1] - p !== 1) begin nerr++; $display("FAIL par_bad_perr got %0d exp 1", pecnt[1] - p); end
    nvec++; if (vcnt[1] - v !== 0) begin nerr++; $display("FAIL par_bad_valid got %0d exp 0", vcnt[1] - v); end
    nvec++; if (ifc1.data_out !== 7'h35) begin nerr++; $display("FAIL par_bad_data_held got %h exp 35", ifc1.data_out); end
  endtask

  task automatic test_frame_err();
    int v = vcnt[0], f = fecnt[0];
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b0, -1);
    repeat (40 * CPB) @(posedge clk);
    #1;
    nvec++; if (fecnt[0] - f !== 1) begin nerr++; $display("FAIL ferr_pulses got %0d exp 1", fecnt[0] - f); end
    nvec++; if (ifc0.busy !== 1'b1) begin nerr++; $display("FAIL ferr_wait_high got %b exp 1", ifc0.busy); end
    nvec++; if (vcnt[0] - v !== 0) begin nerr++; $display("FAIL ferr_valid got %0d exp 0", vcnt[0] - v); end
    rx0 = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    nvec++; if (ifc0.busy !== 1'b0) begin nerr++; $display("FAIL ferr_release got %b exp 0", ifc0.busy); end
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (ifc0.data_out !== 8'h3C) begin nerr++; $display("FAIL ferr_next_data got %h exp 3c", ifc0.data_out); end
    nvec++; if (fecnt[0] - f !== 1) begin nerr++; $display("FAIL ferr_next_pulses got %0d exp 1", fecnt[0] - f); end
  endtask

  task automatic test_overrun();
    int o = ovcnt[0];
    ifc0.data_ready = 1'b0;
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (ifc0.data_valid !== 1'b1) begin nerr++; $display("FAIL ovr_first_valid got %b exp 1", ifc0.data_valid); end
    nvec++; if (ifc0.data_out !== 8'h11) begin nerr++; $display("FAIL ovr_first_data got %h exp 11", ifc0.data_out); end
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (ovcnt[0] - o !== 1) begin nerr++; $display("FAIL ovr_pulses got %0d exp 1", ovcnt[0] - o); end
    nvec++; if (ifc0.data_out !== 8'h11) begin nerr++; $display("FAIL ovr_data_held got %h exp 11", ifc0.data_out); end
    ifc0.data_ready = 1'b1;
    @(posedge clk);
    #1 ifc0.data_ready = 1'b0;
    @(posedge clk);
    #1;
    nvec++; if (ifc0.data_valid !== 1'b0) begin nerr++; $display("FAIL ovr_consume_valid got %b exp 0", ifc0.data_valid); end
    nvec++; if (cap[0] !== 9'h011) begin nerr++; $display("FAIL ovr_consumed got %h exp 11", cap[0]); end
    ifc0.data_ready = 1'b1;
  endtask

  task automatic test_glitch();
    int v = vcnt[0], e = fecnt[0] + pecnt[0] + ovcnt[0];
    rx0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (ifc0.busy !== 1'b1) begin nerr++; $display("FAIL glitch_start_busy got %b exp 1", ifc0.busy); end
    repeat (12) @(posedge clk);
    #1;
    nvec++; if (ifc0.busy !== 1'b0) begin nerr++; $display("FAIL glitch_false_start got %b exp 0", ifc0.busy); end
    nvec++; if (vcnt[0] - v !== 0) begin nerr++; $display("FAIL glitch_no_frame got %0d exp 0", vcnt[0] - v); end
    send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1, 3);
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (ifc0.data_out !== 8'hFF) begin nerr++; $display("FAIL glitch_majority got %h exp ff", ifc0.data_out); end
    nvec++; if (fecnt[0] + pecnt[0] + ovcnt[0] - e !== 0) begin nerr++; $display("FAIL glitch_err_pulses got %0d exp 0", fecnt[0] + pecnt[0] + ovcnt[0] - e); end
  endtask

  task automatic test_rst_midframe();
    logic [7:0] pat = 8'h5A;
    int v = vcnt[2], f = fecnt[2];
    send_bit(2, 1'b0, -1);
    for (int i = 0; i < 4; i++) send_bit(2, pat[i], -1);
    rx2 = pat[4];
    repeat (8) @(posedge clk);
    #1;
    nvec++; if (ifc2.busy !== 1'b1) begin nerr++; $display("FAIL rst_pre_busy got %b exp 1", ifc2.busy); end
    rst = 1'b1;
    #1;
    nvec++; if ({ifc2.data_out, ifc2.data_valid, ifc2.frame_err, ifc2.parity_err, ifc2.overrun_err, ifc2.busy} !== '0) begin
      nerr++; $display("FAIL rst_mid_dut2 got %h exp 0", {ifc2.data_out, ifc2.data_valid, ifc2.frame_err, ifc2.parity_err, ifc2.overrun_err, ifc2.busy}); end
    nvec++; if ({ifc0.data_out, ifc0.data_valid, ifc0.busy} !== '0) begin
      nerr++; $display("FAIL rst_mid_dut0 got %h exp 0", {ifc0.data_out, ifc0.data_valid, ifc0.busy}); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rx2 = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    nvec++; if (vcnt[2] - v !== 0) begin nerr++; $display("FAIL rst_partial_word got %0d exp 0", vcnt[2] - v); end
    send_frame(2, {1'b0, pat}, 8, 1'b0, 1'b0, 2, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (ifc2.data_out !== 8'h5A) begin nerr++; $display("FAIL rst_next_data got %h exp 5a", ifc2.data_out); end
    nvec++; if (vcnt[2] - v !== 1) begin nerr++; $display("FAIL rst_next_valid got %0d exp 1", vcnt[2] - v); end
    nvec++; if (fecnt[2] - f !== 0) begin nerr++; $display("FAIL rst_next_ferr got %0d exp 0", fecnt[2] - f); end
  endtask

  initial begin
    ifc0.data_ready = 1'b1;
    ifc1.data_ready = 1'b1;
    ifc2.data_ready = 1'b1;
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_rst_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
